// File: rtl/ins_fetch_queue.sv
// Instruction fetcher: owns the fetch PC, keeps one request outstanding to the
// instruction cache and buffers returned {instruction, PC} pairs in a circular FIFO.
module ins_fetch_queue #(
    parameter int unsigned           ADDR_WIDTH = 17,
    parameter int unsigned           INS_WIDTH  = 32,
    parameter int unsigned           DEPTH_LOG  = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  ic_req,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    input  logic                  ic_valid,
    input  logic [INS_WIDTH-1:0]  ic_ins,
    output logic                  out_valid,
    output logic [INS_WIDTH-1:0]  out_ins,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready,
    output logic [DEPTH_LOG:0]    count,
    output logic                  busy
);

    localparam int unsigned        DEPTH     = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DEPTH_LOG-1:0]  head_q;
    logic [DEPTH_LOG-1:0]  tail_q;
    logic [DEPTH_LOG:0]    count_q;
    logic [INS_WIDTH-1:0]  mem_ins [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc  [DEPTH];
    logic                  push;
    logic                  pop;

    // A response is only kept when it answers a live (unflushed) request.
    assign push = (state_q == StWait) && ic_valid && !flush;
    assign pop  = out_valid && out_ready && en && !flush;

    assign out_valid = (count_q != '0);
    assign out_ins   = mem_ins[head_q];
    assign out_pc    = mem_pc[head_q];
    assign count     = count_q;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ic_req  <= 1'b0;
            ic_addr <= '0;
        end else begin
            if (flush) begin
                pc_q <= flush_pc;
            end else if (push) begin
                pc_q <= pc_q + ADDR_WIDTH'(4);
            end
            case (state_q)
                StIdle: begin
                    if (en && !flush && (count_q < DEPTH_CNT)) begin
                        ic_req  <= 1'b1;
                        ic_addr <= pc_q;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (ic_valid) begin
                        ic_req  <= 1'b0;
                        state_q <= StIdle;
                    end else if (flush) begin
                        // Request stays on the bus; its answer must be swallowed.
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (ic_valid) begin
                        ic_req  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    ic_req  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + DEPTH_LOG'(1);
            end
            if (pop) begin
                head_q <= head_q + DEPTH_LOG'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (DEPTH_LOG + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (DEPTH_LOG + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ins[tail_q] <= ic_ins;
            mem_pc[tail_q]  <= ic_addr;
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: cycle table for the basic fetch/pop/flush
// flow, then hand-written sequences for fill, flush races, wrap and reset PC.
module tb_ins_fetch_queue;

    localparam int unsigned AW = 17;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_pc = '0;
    logic          ic_valid = 1'b0;
    logic [IW-1:0] ic_ins = '0;
    logic          out_ready = 1'b0;

    logic          ic_req, out_valid, busy;
    logic [AW-1:0] ic_addr, out_pc;
    logic [IW-1:0] out_ins;
    logic [3:0]    count;

    logic          hi_req, hi_out_valid, hi_busy;
    logic [AW-1:0] hi_addr, hi_out_pc;
    logic [IW-1:0] hi_out_ins;
    logic [3:0]    hi_count;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    ins_fetch_queue #(.ADDR_WIDTH(AW), .INS_WIDTH(IW), .DEPTH_LOG(3), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .flush_pc(flush_pc),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_ins(ic_ins),
        .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc), .out_ready(out_ready),
        .count(count), .busy(busy)
    );

    ins_fetch_queue #(.ADDR_WIDTH(AW), .INS_WIDTH(IW), .DEPTH_LOG(3),
                      .RESET_PC(17'h1FFFC)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .flush_pc(flush_pc),
        .ic_req(hi_req), .ic_addr(hi_addr), .ic_valid(ic_valid), .ic_ins(ic_ins),
        .out_valid(hi_out_valid), .out_ins(hi_out_ins), .out_pc(hi_out_pc),
        .out_ready(out_ready), .count(hi_count), .busy(hi_busy)
    );

    typedef struct {
        logic          en, fl, vld, rdy;
        logic [AW-1:0] fpc;
        logic [IW-1:0] ins;
        logic          req, ov, busy;
        logic [AW-1:0] addr, opc;
        logic [IW-1:0] oins;
        logic [3:0]    cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int unsigned en_, fl_, fpc_, vld_, ins_, rdy_,
                               req_, addr_, ov_, opc_, oins_, cnt_, busy_);
        vec_t r;
        r.en = 1'(en_);    r.fl = 1'(fl_);   r.fpc = AW'(fpc_); r.vld = 1'(vld_);
        r.ins = IW'(ins_); r.rdy = 1'(rdy_); r.req = 1'(req_);  r.addr = AW'(addr_);
        r.ov = 1'(ov_);    r.opc = AW'(opc_); r.oins = IW'(oins_); r.cnt = 4'(cnt_);
        r.busy = 1'(busy_);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; flush_pc = '0;
        ic_valid = 1'b0; ic_ins = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!ic_req && n < 20) begin
            step();
            n++;
        end
        chk({name, ".req_seen"}, 32'(ic_req), 32'd1);
    endtask

    // Cache answers in the first cycle the request is visible; data tagged by address.
    task automatic respond(input string name, input logic [AW-1:0] exp_addr);
        wait_req(name);
        chk({name, ".addr"}, 32'(ic_addr), 32'(exp_addr));
        ic_valid = 1'b1;
        ic_ins   = 32'hA500_0000 | {15'h0, ic_addr};
        step();
        ic_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_pop;
        int            npop;
        int            n;

        // en, fl, fpc, vld, ins, rdy | req, addr, ov, opc, oins, cnt, busy
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               0, 0,     0, 0, 0,            0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 0,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 0,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 1, 32'h1111_0000, 1,   1, 0,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               0, 0,     1, 0, 32'h1111_0000, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 4,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 4,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 1, 32'h2222_0004, 1,   1, 4,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               0, 0,     1, 4, 32'h2222_0004, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 8,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 8,     0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 1, 32'h3333_0008, 1,   1, 8,     0, 0, 0,            0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1,               0, 0,     1, 8, 32'h3333_0008, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,               0, 0,     1, 8, 32'h3333_0008, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 'hC,   1, 8, 32'h3333_0008, 1, 1));
        tbl.push_back(v(1, 1, 'h80, 0, 0, 1,            1, 'hC,   0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 1, 32'hBAD, 1,         1, 'hC,   0, 0, 0,            0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               0, 0,     0, 0, 0,            0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,               1, 'h80,  0, 0, 0,            0, 1));

        // Basic flow, en=0 hold, flush in WAIT and redirect.
        do_reset();
        chk("reset.ic_addr", 32'(ic_addr), 32'h0);
        foreach (tbl[i]) begin
            step();
            chk($sformatf("row%0d.req", i), 32'(ic_req), 32'(tbl[i].req));
            chk($sformatf("row%0d.valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            if (tbl[i].req) chk($sformatf("row%0d.addr", i), 32'(ic_addr), 32'(tbl[i].addr));
            if (tbl[i].ov) begin
                chk($sformatf("row%0d.out_pc", i), 32'(out_pc), 32'(tbl[i].opc));
                chk($sformatf("row%0d.out_ins", i), out_ins, tbl[i].oins);
            end
            en = tbl[i].en; flush = tbl[i].fl; flush_pc = tbl[i].fpc;
            ic_valid = tbl[i].vld; ic_ins = tbl[i].ins; out_ready = tbl[i].rdy;
        end

        // Fill to DEPTH with no consumer, then one pop releases the next request.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) respond($sformatf("fill%0d", i), AW'(4 * i));
        chk("fill.count", 32'(count), 32'd8);
        chk("fill.req_blocked", 32'(ic_req), 32'd0);
        step();
        step();
        chk("fill.req_still_blocked", 32'(ic_req), 32'd0);
        chk("fill.head_pc", 32'(out_pc), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fill.count_after_pop", 32'(count), 32'd7);
        chk("fill.head_after_pop", 32'(out_pc), 32'h4);
        respond("fill.next", AW'(32'h20));

        // Flush while waiting: late response dropped, fetch restarts at flush_pc.
        do_reset();
        en = 1'b1;
        respond("disc.first", '0);
        wait_req("disc.second");
        chk("disc.second.addr", 32'(ic_addr), 32'h4);
        flush = 1'b1; flush_pc = AW'(32'h100);
        step();
        flush = 1'b0;
        chk("disc.busy", 32'(busy), 32'd1);
        chk("disc.req_held", 32'(ic_req), 32'd1);
        chk("disc.out_valid", 32'(out_valid), 32'd0);
        step();
        chk("disc.still_busy", 32'(busy), 32'd1);
        ic_valid = 1'b1; ic_ins = 32'hDEAD_BEEF;
        step();
        ic_valid = 1'b0;
        chk("disc.dropped_count", 32'(count), 32'd0);
        chk("disc.idle", 32'(busy), 32'd0);
        chk("disc.req_low", 32'(ic_req), 32'd0);
        respond("disc.redirect", AW'(32'h100));
        chk("disc.redirect_pc", 32'(out_pc), 32'h100);

        // Flush and response in the same cycle.
        do_reset();
        en = 1'b1;
        respond("race.first", '0);
        wait_req("race.second");
        ic_valid = 1'b1; ic_ins = 32'h1234_5678; flush = 1'b1; flush_pc = AW'(32'h40);
        step();
        ic_valid = 1'b0; flush = 1'b0;
        chk("race.count", 32'(count), 32'd0);
        chk("race.out_valid", 32'(out_valid), 32'd0);
        chk("race.idle", 32'(busy), 32'd0);
        chk("race.req_low", 32'(ic_req), 32'd0);
        step();
        chk("race.req", 32'(ic_req), 32'd1);
        chk("race.addr", 32'(ic_addr), 32'h40);

        // Push and pop together at count 3, then stream past pointer wrap.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) respond($sformatf("pp%0d", i), AW'(4 * i));
        wait_req("pp.fourth");
        chk("pp.addr", 32'(ic_addr), 32'hC);
        chk("pp.head_before", 32'(out_pc), 32'h0);
        ic_valid = 1'b1; ic_ins = 32'hA500_0000 | {15'h0, ic_addr}; out_ready = 1'b1;
        step();
        ic_valid = 1'b0; out_ready = 1'b0;
        chk("pp.count", 32'(count), 32'd3);
        chk("pp.head_after", 32'(out_pc), 32'h4);
        out_ready = 1'b1;
        exp_pop = AW'(4);
        npop = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                chk($sformatf("stream%0d.pc", npop), 32'(out_pc), 32'(exp_pop));
                chk($sformatf("stream%0d.ins", npop), out_ins, 32'hA500_0000 | {15'h0, exp_pop});
                exp_pop = exp_pop + AW'(4);
                npop++;
            end
            if (ic_valid) begin
                ic_valid = 1'b0;
            end else if (ic_req) begin
                ic_valid = 1'b1;
                ic_ins   = 32'hA500_0000 | {15'h0, ic_addr};
            end
            step();
        end
        ic_valid = 1'b0;
        chk("stream.enough_pops", 32'(npop >= 20), 32'd1);

        // Non-zero reset PC wraps; async reset in WAIT drops the request at once.
        do_reset();
        en = 1'b1;
        n = 0;
        while (!hi_req && n < 20) begin
            step();
            n++;
        end
        chk("rpc.req", 32'(hi_req), 32'd1);
        chk("rpc.addr0", 32'(hi_addr), 32'h1FFFC);
        ic_valid = 1'b1; ic_ins = 32'hCAFE_0001;
        step();
        ic_valid = 1'b0;
        chk("rpc.count", 32'(hi_count), 32'd1);
        chk("rpc.out_pc", 32'(hi_out_pc), 32'h1FFFC);
        chk("rpc.out_ins", hi_out_ins, 32'hCAFE_0001);
        step();
        chk("rpc.req1", 32'(hi_req), 32'd1);
        chk("rpc.addr_wrap", 32'(hi_addr), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst.req", 32'(hi_req), 32'd0);
        chk("arst.count", 32'(hi_count), 32'd0);
        chk("arst.busy", 32'(hi_busy), 32'd0);
        chk("arst.out_valid", 32'(hi_out_valid), 32'd0);
        step();
        rst = 1'b0;
        n = 0;
        while (!hi_req && n < 20) begin
            step();
            n++;
        end
        chk("arst.req_again", 32'(hi_req), 32'd1);
        chk("arst.pc_reloaded", 32'(hi_addr), 32'h1FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
